// File: rtl/vga_pkg.sv
// Shared constants, timing helpers and pipeline record for the VGA scan-out engine.
package vga_pkg;

    // Total pixels per line or lines per frame from active size, porches and sync width.
    function automatic int unsigned calc_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    // Offset that centres a scaled image inside the active area.
    function automatic int unsigned calc_origin(input int unsigned res, input int unsigned img,
                                                input int unsigned scale);
        return (res - img * scale) / 2;
    endfunction

    // RGB565 field positions used to form RGB444 (top four bits of each channel).
    localparam int unsigned R_HI = 15;
    localparam int unsigned R_LO = 12;
    localparam int unsigned G_HI = 10;
    localparam int unsigned G_LO = 7;
    localparam int unsigned B_HI = 4;
    localparam int unsigned B_LO = 1;

    // Control flags carried alongside the fetched pixel into the output stage.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic in_win;
        logic en;
    } stage1_t;

endpackage

// File: rtl/vga_timing_core.sv
// Pixel-enable divider, h/v counters and raw (stage-0) sync/de/frame decode.
module vga_timing_core
    import vga_pkg::*;
#(
    parameter int unsigned H_RES   = 640,
    parameter int unsigned H_FP    = 16,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BP    = 48,
    parameter int unsigned V_RES   = 480,
    parameter int unsigned V_FP    = 10,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BP    = 33,
    parameter logic        H_POL   = 1'b0,
    parameter logic        V_POL   = 1'b0,
    parameter int unsigned PIX_DIV = 4,
    localparam int unsigned H_TOT  = calc_total(H_RES, H_FP, H_SYNC, H_BP),
    localparam int unsigned V_TOT  = calc_total(V_RES, V_FP, V_SYNC, V_BP),
    localparam int unsigned HW     = $clog2(H_TOT),
    localparam int unsigned VW     = $clog2(V_TOT)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          tick,
    output logic [HW-1:0] h,
    output logic [HW-1:0] h_nxt,
    output logic [VW-1:0] v,
    output logic [VW-1:0] v_nxt,
    output logic          frame_wrap,
    output logic          de,
    output logic          hs,
    output logic          vs
);

    localparam int unsigned DW = $clog2(PIX_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_RES);
    localparam logic [VW-1:0] V_ACT    = VW'(V_RES);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_RES + H_FP);
    localparam logic [HW-1:0] HS_LEN   = HW'(H_SYNC);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_RES + V_FP);
    localparam logic [VW-1:0] VS_LEN   = VW'(V_SYNC);

    logic [DW-1:0] div_cnt;

    // Next-position, tick and raw timing decode from the current counters.
    always_comb begin
        tick       = (div_cnt == DIV_LAST);
        h_nxt      = (h == H_LAST) ? '0 : h + 1'b1;
        v_nxt      = v;
        if (h == H_LAST) begin
            v_nxt = (v == V_LAST) ? '0 : v + 1'b1;
        end
        frame_wrap = tick && (h == H_LAST) && (v == V_LAST);
        de         = (h < H_ACT) && (v < V_ACT);
        // Range checks use unsigned wrap-around: (x - start) < len.
        hs         = ((h - HS_BEG) < HS_LEN) ? H_POL : ~H_POL;
        vs         = ((v - VS_BEG) < VS_LEN) ? V_POL : ~V_POL;
    end

    // Divider and raster counters; counters advance only on tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            h       <= '0;
            v       <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                h <= h_nxt;
                v <= v_nxt;
            end
        end
    end

endmodule

// File: rtl/vga_fb_scanout.sv
// VGA scan-out: timing core plus window/address generation and the output stage.
module vga_fb_scanout
    import vga_pkg::*;
#(
    parameter int unsigned H_RES   = 640,
    parameter int unsigned V_RES   = 480,
    parameter int unsigned H_FP    = 16,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BP    = 48,
    parameter int unsigned V_FP    = 10,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BP    = 33,
    parameter logic        H_POL   = 1'b0,
    parameter logic        V_POL   = 1'b0,
    parameter int unsigned PIX_DIV = 4,
    parameter int unsigned IMG_W   = 160,
    parameter int unsigned IMG_H   = 120,
    parameter int unsigned SCALE   = 4,
    parameter int unsigned ADDR_W  = 15,
    parameter int unsigned RD_LAT  = 2,
    parameter logic [11:0] BORDER  = 12'h000
) (
    input  logic              CLK,
    input  logic              RST_BTN,
    input  logic              i_en,
    input  logic [15:0]       doutb,
    output logic [ADDR_W-1:0] addrb,
    output logic              o_hs,
    output logic              o_vs,
    output logic              o_de,
    output logic [3:0]        o_r,
    output logic [3:0]        o_g,
    output logic [3:0]        o_b,
    output logic              o_frame
);

    localparam int unsigned H_TOT = calc_total(H_RES, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOT = calc_total(V_RES, V_FP, V_SYNC, V_BP);
    localparam int unsigned HW    = $clog2(H_TOT);
    localparam int unsigned VW    = $clog2(V_TOT);
    localparam int unsigned X0    = calc_origin(H_RES, IMG_W, SCALE);
    localparam int unsigned Y0    = calc_origin(V_RES, IMG_H, SCALE);
    localparam int unsigned SW    = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [HW-1:0]     WX0      = HW'(X0);
    localparam logic [HW-1:0]     WXN      = HW'(IMG_W * SCALE);
    localparam logic [HW-1:0]     WXL      = HW'(X0 + IMG_W * SCALE - 1);
    localparam logic [VW-1:0]     WY0      = VW'(Y0);
    localparam logic [VW-1:0]     WYN      = VW'(IMG_H * SCALE);
    localparam logic [SW-1:0]     S_LAST   = SW'(SCALE - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
    // Read latency only constrains the BRAM; data is always sampled PIX_DIV cycles later.
    localparam int unsigned unused_rd_lat = RD_LAT;

    logic              tick, frame_wrap, de_raw, hs_raw, vs_raw;
    logic [HW-1:0]     h, h_nxt;
    logic [VW-1:0]     v, v_nxt;
    logic              h_win, v_win, hn_win, vn_win;
    logic              enter, advance, line_done;
    logic [SW-1:0]     sx, sy;
    logic [ADDR_W-1:0] row_base;
    logic              en_frame;
    stage1_t           s0, s1;
    logic [11:0]       pix_q, rgb;
    logic              unused_doutb;

    assign unused_doutb = ^{doutb[11], doutb[6:5], doutb[0]};

    vga_timing_core #(
        .H_RES  (H_RES),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_RES  (V_RES),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP),
        .H_POL  (H_POL),
        .V_POL  (V_POL),
        .PIX_DIV(PIX_DIV)
    ) u_timing (
        .clk       (CLK),
        .rst       (RST_BTN),
        .tick      (tick),
        .h         (h),
        .h_nxt     (h_nxt),
        .v         (v),
        .v_nxt     (v_nxt),
        .frame_wrap(frame_wrap),
        .de        (de_raw),
        .hs        (hs_raw),
        .vs        (vs_raw)
    );

    // Window membership of the current and the upcoming pixel, plus address-walk events.
    always_comb begin
        h_win     = (h - WX0) < WXN;
        v_win     = (v - WY0) < WYN;
        hn_win    = (h_nxt - WX0) < WXN;
        vn_win    = (v_nxt - WY0) < WYN;
        enter     = tick && vn_win && (h_nxt == WX0);
        advance   = tick && vn_win && hn_win && (h_nxt != WX0);
        line_done = tick && v_win && (h == WXL);
        s0        = '{de: de_raw, hs: hs_raw, vs: vs_raw, in_win: h_win && v_win, en: en_frame};
    end

    // Incremental address walk: addrb is loaded on the tick that moves onto the pixel it serves.
    always_ff @(posedge CLK) begin
        if (RST_BTN) begin
            addrb    <= '0;
            row_base <= '0;
            sx       <= '0;
            sy       <= '0;
        end else begin
            if (frame_wrap) begin
                row_base <= '0;
                sy       <= '0;
            end else if (line_done) begin
                if (sy == S_LAST) begin
                    sy       <= '0;
                    row_base <= row_base + ROW_STEP;
                end else begin
                    sy <= sy + 1'b1;
                end
            end
            if (enter) begin
                sx    <= '0;
                // Row base clears on this same tick at frame start, so bypass it here.
                addrb <= frame_wrap ? '0 : row_base;
            end else if (advance) begin
                if (sx == S_LAST) begin
                    sx    <= '0;
                    addrb <= addrb + 1'b1;
                end else begin
                    sx <= sx + 1'b1;
                end
            end
        end
    end

    // Output stage: capture BRAM data with the stage-0 flags; latch enable at frame start.
    always_ff @(posedge CLK) begin
        if (RST_BTN) begin
            s1       <= '{de: 1'b0, hs: ~H_POL, vs: ~V_POL, in_win: 1'b0, en: 1'b0};
            pix_q    <= '0;
            o_frame  <= 1'b0;
            en_frame <= 1'b0;
        end else begin
            o_frame <= frame_wrap;
            if (o_frame) begin
                en_frame <= i_en;
            end
            if (tick) begin
                s1    <= s0;
                pix_q <= {doutb[R_HI:R_LO], doutb[G_HI:G_LO], doutb[B_HI:B_LO]};
            end
        end
    end

    // Colour select: image, border, or black during blanking.
    always_comb begin
        rgb = '0;
        if (s1.de) begin
            rgb = (s1.in_win && s1.en) ? pix_q : BORDER;
        end
        o_de = s1.de;
        o_hs = s1.hs;
        o_vs = s1.vs;
        o_r  = rgb[11:8];
        o_g  = rgb[7:4];
        o_b  = rgb[3:0];
    end

endmodule

// File: doc/vga_fb_scanout.md
# vga_fb_scanout

Parametrised VGA scan-out engine: it generates display timing from the 100 MHz board clock using a pixel-enable divider, so no clocking primitive is needed. It fetches a scaled, centred framebuffer image from a synchronous BRAM port and drives 4-bit RGB with sync and blanking aligned to the fetched data. It sits between the MP3 player's framebuffer BRAM (port B) and the VGA connector, and replaces the fixed 640x480 timing-plus-card arrangement.

## Interface
Parameters:
- H_RES 640, V_RES 480: active pixels and lines.
- H_FP 16, H_SYNC 96, H_BP 48; V_FP 10, V_SYNC 2, V_BP 33: porch and sync widths.
- H_POL 0, V_POL 0: sync active level (0 = active-low).
- PIX_DIV 4: CLK cycles per pixel (100 MHz / 4 = 25 MHz).
- IMG_W 160, IMG_H 120: framebuffer dimensions in pixels.
- SCALE 4: integer pixel replication factor in x and y. Must be a power of two, 1..8.
- ADDR_W 15: BRAM address width. IMG_W*IMG_H must be ≤ 2^ADDR_W.
- RD_LAT 2: BRAM read latency in CLK cycles. Must satisfy 1 ≤ RD_LAT ≤ PIX_DIV-1.
- BORDER 12'h000: RGB444 colour shown outside the image window and while disabled.

Ports:
- CLK in 1: system clock. One clock domain only.
- RST_BTN in 1: reset, synchronous, active-high.
- i_en in 1: image enable; sampled only at frame start.
- doutb in 16: BRAM read data, RGB565.
- addrb out ADDR_W: BRAM read address.
- o_hs, o_vs out 1: syncs.
- o_de out 1: active video.
- o_r, o_g, o_b out 4 each: colour. Forced to 0 when o_de=0.
- o_frame out 1: one-CLK pulse when the counters wrap to (0,0).

## Operation
- Tick: a mod-PIX_DIV divider asserts `tick` for one CLK every PIX_DIV cycles. All counters advance only on tick.
- Counters:
  - h runs 0..H_TOT-1 and v runs 0..V_TOT-1, where H_TOT = H_RES+H_FP+H_SYNC+H_BP and V_TOT is the vertical equivalent (800 x 525 by default).
  - Active region is h<H_RES and v<V_RES.
  - hs is active for H_RES+H_FP ≤ h < H_RES+H_FP+H_SYNC; vs uses the same form with v.
- Window:
  - X0 = (H_RES-IMG_W*SCALE)/2 and Y0 = (V_RES-IMG_H*SCALE)/2, both constants.
  - A pixel is inside the window when X0 ≤ h < X0+IMG_W*SCALE and the equivalent holds for v.
- Address generation is incremental; no multiplier.
  - Sub-counters sx and sy run 0..SCALE-1. The column address increments when sx wraps.
  - A row-base register adds IMG_W when sy wraps at end of line.
  - Row base resets to 0 at frame start.
  - Outside the window, addrb holds its last value.
- Fetch stage (stage 0): the address for pixel (h,v) is presented on addrb on that pixel's tick and held for PIX_DIV cycles.
- Output stage (stage 1): on the next tick, doutb is captured together with the stage-0 de, hs, vs, in-window flag and enable. Colour mapping: r=d[15:12], g=d[10:7], b=d[4:1].
  - Pixels outside the window, or any pixel while en_frame=0, output BORDER.
- Frame enable: en_frame is loaded from i_en on the o_frame cycle only. Toggling i_en mid-frame has no visible effect until the next frame (no tearing).

## Timing
- All outputs lag the counters by exactly one pixel period (PIX_DIV CLK). Syncs and de are delayed identically to colour, so relative alignment is exact.
- BRAM data is sampled PIX_DIV cycles after the address changes; the RD_LAT ≤ PIX_DIV-1 constraint guarantees it is valid.
- Reset values:
  - Counters, divider, row base and addrb are 0.
  - o_de, o_frame and RGB are 0.
  - o_hs and o_vs sit at their inactive level (~H_POL, ~V_POL). en_frame is 0.
  - The first tick occurs PIX_DIV cycles after reset release.
- Reset asserted mid-line or mid-frame: on the next CLK, all state returns to reset values and the timing restarts from (0,0).
- Wrap: on a tick at h=H_TOT-1, v=V_TOT-1, counters go to (0,0) and o_frame pulses that same CLK.
- Line and frame periods: line = H_TOT*PIX_DIV CLK = 3200; frame = 1,680,000 CLK.

## Structure
- Package vga_pkg holds:
  - localparam functions for H_TOT, V_TOT, X0 and Y0;
  - RGB565-to-RGB444 field positions;
  - a packed struct for the stage-1 pipeline record (de, hs, vs, in_win, en).
- Sub-module vga_timing_core contains the divider, h/v counters, sync, de and frame decode, and outputs raw stage-0 signals. The top level adds window/address logic and the output stage.

## Test plan
- Reset: hold RST_BTN 3 cycles → o_hs=1, o_vs=1, o_de=0, RGB=0, addrb=0, o_frame=0. Release, then first tick after 4 CLK.
- Line timing (default parameters):
  - o_hs low for 384 CLK, period 3200 CLK; o_de high 2560 CLK per active line.
  - o_vs low for 2 lines, period 525 lines.
- Addressing (default, X0=Y0=0):
  - Line 0 addrb sequence is 0,1,2…159, each held 16 CLK.
  - Lines 0–3 repeat row 0, line 4 starts at 160, and the final active pixel reads 19199.
- Data alignment: BRAM model with RD_LAT=2 returning doutb=16'hF800 at address 0 → first o_de pixel has RGB=(F,0,0). The o_de rising edge is exactly 4 CLK after h=0.
- Window and border: IMG_W=100, SCALE=2, BORDER=12'h00F → X0=220, Y0=120; pixels h<220 or v<120 show blue, and the first image pixel appears at h=220.
- Enable and reset mid-operation:
  - Drop i_en at line 200 → image unchanged through the current frame; BORDER across the whole active area from the next o_frame.
  - Assert RST_BTN mid-line → reset values on the next CLK.
